// File: rtl/acc_queue_if.sv
// req_if: valid/ready handshake bundle.
//   valid - driven by the sender
//   ready - driven by the receiver
interface req_if;
  logic valid;
  logic ready;

  modport sender   (output valid, input  ready);
  modport receiver (input  valid, output ready);
endinterface

// File: rtl/acc_queue.sv
// acc_queue: in-order reservation queue in front of the accumulator unit.
// Each entry holds one FPR operand (valid, ROB tag, data) and the branch
// depth it was issued under. Operands wake up from the CDB. Only the head
// can dispatch, and only once it is non-speculative and its operand is ready.
//
// Ports:
//   clk, reset    - clock; synchronous active-high reset
//   fpr_read[2]   - register-read results (only element 0 is the operand)
//   fpr_cdb       - common data bus broadcast (operand wakeup)
//   b_count_next  - branch depth of the instruction being issued
//   b_commit      - one outstanding branch resolved correctly this cycle
//   failure       - branch mispredict; drop every speculative entry
//   issue_req     - issue handshake (valid in, ready out)
//   acc_req       - accumulator handshake (valid out, ready in)
//   acc_data      - head operand data
//   occupancy     - number of live entries

package acc_queue_pkg;
  parameter int unsigned N_B_ENTRY = 4;
  parameter int unsigned ROB_TAG_W = 5;

  typedef struct packed {
    logic                 valid;
    logic [ROB_TAG_W-1:0] tag;
    logic [31:0]          data;
  } cdb_t;
endpackage

module acc_queue
  import acc_queue_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned B_WIDTH = $clog2(N_B_ENTRY) + 1,
  parameter int unsigned DATA_W  = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  cdb_t                     fpr_read [2],
  input  cdb_t                     fpr_cdb,
  input  logic [B_WIDTH-1:0]       b_count_next,
  input  logic                     b_commit,
  input  logic                     failure,
  req_if.receiver                  issue_req,
  req_if.sender                    acc_req,
  output logic [DATA_W-1:0]        acc_data,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [DEPTH-1:0]     ent_valid;
  logic [ROB_TAG_W-1:0] ent_tag  [DEPTH];
  logic [DATA_W-1:0]    ent_data [DEPTH];
  logic [B_WIDTH-1:0]   ent_bcnt [DEPTH];

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;

  logic             dispatch;
  logic             enqueue;
  logic             head_eligible;
  logic             issue_ready;
  logic [CNT_W-1:0] flush_keep;

  logic unused_fpr_read1;
  assign unused_fpr_read1 = ^fpr_read[1];

  // Head eligibility uses registered state only, so acc_req.ready never
  // feeds back into acc_req.valid.
  assign head_eligible = (count != '0) && (ent_bcnt[head] == '0) && ent_valid[head];
  assign acc_req.valid = head_eligible;
  assign acc_data      = ent_data[head];
  assign dispatch      = head_eligible && acc_req.ready;

  assign issue_ready     = !failure && ((count < CNT_W'(DEPTH)) || dispatch);
  assign issue_req.ready = issue_ready;
  assign enqueue         = issue_req.valid && issue_ready;

  assign occupancy = count;

  // Number of consecutive live entries from the head with zero branch depth.
  // Depth is non-decreasing head to tail, so this prefix is exactly the set
  // of confirmed entries that survive a mispredict.
  always_comb begin
    logic run;
    flush_keep = '0;
    run        = 1'b1;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (run && (CNT_W'(i) < count) && (ent_bcnt[head + PTR_W'(i)] == '0)) begin
        flush_keep = flush_keep + CNT_W'(1);
      end else begin
        run = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (dispatch) begin
        head <= head + PTR_W'(1);
      end
      if (failure) begin
        tail  <= head + flush_keep[PTR_W-1:0];
        count <= flush_keep - CNT_W'(dispatch);
      end else begin
        if (enqueue) begin
          tail <= tail + PTR_W'(1);
        end
        count <= count + CNT_W'(enqueue) - CNT_W'(dispatch);
      end
    end
  end

  // Entry payload carries no reset; liveness is governed by head/count.
  // The tail write follows the snoop loop so a new entry overrides any
  // stale update to the same slot.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (!ent_valid[i] && fpr_cdb.valid && (fpr_cdb.tag == ent_tag[i])) begin
        ent_valid[i] <= 1'b1;
        ent_data[i]  <= DATA_W'(fpr_cdb.data);
      end
      if (ent_bcnt[i] != '0) begin
        ent_bcnt[i] <= ent_bcnt[i] - B_WIDTH'(b_commit);
      end
    end
    if (enqueue) begin
      ent_tag[tail]   <= fpr_read[0].tag;
      ent_valid[tail] <= fpr_read[0].valid ||
                         (fpr_cdb.valid && (fpr_cdb.tag == fpr_read[0].tag));
      ent_data[tail]  <= fpr_read[0].valid ? DATA_W'(fpr_read[0].data)
                                           : DATA_W'(fpr_cdb.data);
      ent_bcnt[tail]  <= b_count_next;
    end
  end

endmodule

// File: tb/tb_acc_queue.sv
module tb_acc_queue;
  import acc_queue_pkg::*;

  logic        clk;
  logic        reset;
  cdb_t        fpr_read [2];
  cdb_t        fpr_cdb;
  logic [2:0]  b_count_next;
  logic        b_commit;
  logic        failure;
  logic [31:0] acc_data;
  logic [2:0]  occupancy;

  req_if issue_bus ();
  req_if acc_bus ();

  int errors = 0;
  int checks = 0;

  acc_queue #(.DEPTH(4), .B_WIDTH(3), .DATA_W(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .fpr_read     (fpr_read),
    .fpr_cdb      (fpr_cdb),
    .b_count_next (b_count_next),
    .b_commit     (b_commit),
    .failure      (failure),
    .issue_req    (issue_bus),
    .acc_req      (acc_bus),
    .acc_data     (acc_data),
    .occupancy    (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [4:0] tag, input logic vld,
                      input logic [31:0] data, input logic [2:0] bcnt);
    issue_bus.valid = 1'b1;
    fpr_read[0]     = '{vld, tag, data};
    b_count_next    = bcnt;
    tick();
    issue_bus.valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    issue_bus.valid = 1'b1;
    fpr_read[0] = '{1'b1, 5'd3, 32'hbad0bad0};
    tick();
    tick();
    reset = 1'b0;
    issue_bus.valid = 1'b0;
    #1;
    if (occupancy !== 3'd0) begin errors++; $display("FAIL reset_occ got=%0d exp=0", occupancy); end
    checks++;
    if (acc_bus.valid !== 1'b0) begin errors++; $display("FAIL reset_acc_valid got=%0b exp=0", acc_bus.valid); end
    checks++;
    if (issue_bus.ready !== 1'b1) begin errors++; $display("FAIL reset_issue_ready got=%0b exp=1", issue_bus.ready); end
    checks++;
  endtask

  task automatic test_fill_drain();
    int exp_occ [5] = '{4, 4, 3, 2, 1};
    acc_bus.ready = 1'b0;
    for (int i = 1; i <= 4; i++) push(5'(i), 1'b1, 32'(i), 3'd0);
    #1;
    if (occupancy !== 3'd4) begin errors++; $display("FAIL fill_occ got=%0d exp=4", occupancy); end
    checks++;
    if (issue_bus.ready !== 1'b0) begin errors++; $display("FAIL full_issue_ready got=%0b exp=0", issue_bus.ready); end
    checks++;
    acc_bus.ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i == 0) begin
        issue_bus.valid = 1'b1;
        fpr_read[0] = '{1'b1, 5'd5, 32'h5};
        b_count_next = 3'd0;
      end
      #1;
      if (i == 0 && issue_bus.ready !== 1'b1) begin errors++; $display("FAIL full_dispatch_ready got=%0b exp=1", issue_bus.ready); end
      if (i == 0) checks++;
      if (acc_bus.valid !== 1'b1) begin errors++; $display("FAIL drain_valid[%0d] got=%0b exp=1", i, acc_bus.valid); end
      checks++;
      if (acc_data !== 32'(i + 1)) begin errors++; $display("FAIL drain_data[%0d] got=%0h exp=%0h", i, acc_data, i + 1); end
      checks++;
      if (occupancy !== 3'(exp_occ[i])) begin errors++; $display("FAIL drain_occ[%0d] got=%0d exp=%0d", i, occupancy, exp_occ[i]); end
      checks++;
      tick();
      issue_bus.valid = 1'b0;
    end
    #1;
    if (occupancy !== 3'd0) begin errors++; $display("FAIL drain_empty_occ got=%0d exp=0", occupancy); end
    checks++;
    if (acc_bus.valid !== 1'b0) begin errors++; $display("FAIL drain_empty_valid got=%0b exp=0", acc_bus.valid); end
    checks++;
  endtask

  task automatic test_cdb_wakeup();
    acc_bus.ready = 1'b1;
    push(5'd7, 1'b0, 32'hdead, 3'd0);
    #1;
    if (acc_bus.valid !== 1'b0) begin errors++; $display("FAIL wake_pending_valid got=%0b exp=0", acc_bus.valid); end
    checks++;
    if (occupancy !== 3'd1) begin errors++; $display("FAIL wake_occ got=%0d exp=1", occupancy); end
    checks++;
    fpr_cdb = '{1'b1, 5'd6, 32'h12345678};
    tick();
    fpr_cdb = '0;
    #1;
    if (acc_bus.valid !== 1'b0) begin errors++; $display("FAIL wake_wrong_tag got=%0b exp=0", acc_bus.valid); end
    checks++;
    fpr_cdb = '{1'b1, 5'd7, 32'h3f800000};
    #1;
    if (acc_bus.valid !== 1'b0) begin errors++; $display("FAIL wake_same_cycle_valid got=%0b exp=0", acc_bus.valid); end
    checks++;
    tick();
    fpr_cdb = '0;
    #1;
    if (acc_bus.valid !== 1'b1) begin errors++; $display("FAIL wake_valid got=%0b exp=1", acc_bus.valid); end
    checks++;
    if (acc_data !== 32'h3f800000) begin errors++; $display("FAIL wake_data got=%0h exp=3f800000", acc_data); end
    checks++;
    tick();
    if (occupancy !== 3'd0) begin errors++; $display("FAIL wake_drained got=%0d exp=0", occupancy); end
    checks++;
    fpr_cdb = '{1'b1, 5'd9, 32'h40000000};
    push(5'd9, 1'b0, 32'hbeef, 3'd0);
    fpr_cdb = '0;
    #1;
    if (acc_bus.valid !== 1'b1) begin errors++; $display("FAIL bypass_valid got=%0b exp=1", acc_bus.valid); end
    checks++;
    if (acc_data !== 32'h40000000) begin errors++; $display("FAIL bypass_data got=%0h exp=40000000", acc_data); end
    checks++;
    tick();
    if (occupancy !== 3'd0) begin errors++; $display("FAIL bypass_drained got=%0d exp=0", occupancy); end
    checks++;
  endtask

  task automatic test_branch_depth();
    acc_bus.ready = 1'b1;
    push(5'd1, 1'b1, 32'ha, 3'd1);
    push(5'd2, 1'b1, 32'hb, 3'd1);
    push(5'd3, 1'b1, 32'hc, 3'd2);
    #1;
    if (acc_bus.valid !== 1'b0) begin errors++; $display("FAIL spec_blocked got=%0b exp=0", acc_bus.valid); end
    checks++;
    if (occupancy !== 3'd3) begin errors++; $display("FAIL spec_occ got=%0d exp=3", occupancy); end
    checks++;
    b_commit = 1'b1;
    tick();
    b_commit = 1'b0;
    #1;
    if (acc_bus.valid !== 1'b1 || acc_data !== 32'ha) begin errors++; $display("FAIL commit1_first got=%0b/%0h exp=1/a", acc_bus.valid, acc_data); end
    checks++;
    tick();
    if (acc_bus.valid !== 1'b1 || acc_data !== 32'hb) begin errors++; $display("FAIL commit1_second got=%0b/%0h exp=1/b", acc_bus.valid, acc_data); end
    checks++;
    tick();
    if (acc_bus.valid !== 1'b0 || occupancy !== 3'd1) begin errors++; $display("FAIL commit1_third_held got=%0b/%0d exp=0/1", acc_bus.valid, occupancy); end
    checks++;
    b_commit = 1'b1;
    tick();
    b_commit = 1'b0;
    #1;
    if (acc_bus.valid !== 1'b1 || acc_data !== 32'hc) begin errors++; $display("FAIL commit2_third got=%0b/%0h exp=1/c", acc_bus.valid, acc_data); end
    checks++;
    tick();
    if (occupancy !== 3'd0) begin errors++; $display("FAIL commit2_drained got=%0d exp=0", occupancy); end
    checks++;
  endtask

  task automatic test_failure_partial();
    acc_bus.ready = 1'b0;
    push(5'd11, 1'b1, 32'h11, 3'd0);
    push(5'd12, 1'b1, 32'h12, 3'd0);
    push(5'd13, 1'b1, 32'h13, 3'd1);
    push(5'd14, 1'b1, 32'h14, 3'd2);
    acc_bus.ready = 1'b1;
    failure = 1'b1;
    issue_bus.valid = 1'b1;
    fpr_read[0] = '{1'b1, 5'd15, 32'h99};
    b_count_next = 3'd0;
    #1;
    if (issue_bus.ready !== 1'b0) begin errors++; $display("FAIL fail_issue_ready got=%0b exp=0", issue_bus.ready); end
    checks++;
    if (acc_bus.valid !== 1'b1 || acc_data !== 32'h11) begin errors++; $display("FAIL fail_head_dispatch got=%0b/%0h exp=1/11", acc_bus.valid, acc_data); end
    checks++;
    tick();
    failure = 1'b0;
    issue_bus.valid = 1'b0;
    acc_bus.ready = 1'b0;
    #1;
    if (occupancy !== 3'd1) begin errors++; $display("FAIL fail_occ got=%0d exp=1", occupancy); end
    checks++;
    if (acc_bus.valid !== 1'b1 || acc_data !== 32'h12) begin errors++; $display("FAIL fail_survivor got=%0b/%0h exp=1/12", acc_bus.valid, acc_data); end
    checks++;
    acc_bus.ready = 1'b1;
    tick();
    if (occupancy !== 3'd0 || acc_bus.valid !== 1'b0) begin errors++; $display("FAIL fail_drained got=%0d/%0b exp=0/0", occupancy, acc_bus.valid); end
    checks++;
  endtask

  task automatic test_failure_all();
    acc_bus.ready = 1'b1;
    push(5'd20, 1'b1, 32'h20, 3'd1);
    push(5'd21, 1'b1, 32'h21, 3'd2);
    failure = 1'b1;
    b_commit = 1'b1;
    tick();
    failure = 1'b0;
    b_commit = 1'b0;
    #1;
    if (occupancy !== 3'd0) begin errors++; $display("FAIL flush_all_occ got=%0d exp=0", occupancy); end
    checks++;
    if (acc_bus.valid !== 1'b0) begin errors++; $display("FAIL flush_all_valid got=%0b exp=0", acc_bus.valid); end
    checks++;
    if (issue_bus.ready !== 1'b1) begin errors++; $display("FAIL flush_all_ready got=%0b exp=1", issue_bus.ready); end
    checks++;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    fpr_read[0] = '0;
    fpr_read[1] = '0;
    fpr_cdb = '0;
    b_count_next = '0;
    b_commit = 1'b0;
    failure = 1'b0;
    issue_bus.valid = 1'b0;
    acc_bus.ready = 1'b0;
    #2;
    test_reset();
    test_fill_drain();
    test_cdb_wakeup();
    test_branch_depth();
    test_failure_partial();
    test_failure_all();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/acc_queue.md
Name: acc_queue

Overview:
- Multi-entry, in-order reservation queue feeding the accumulator unit.
- Each entry holds one FPR operand (cdb_t: valid, ROB tag, 32-bit data) and a speculative branch depth.
- Operands wake up from the CDB, and only the head dispatches, once it is non-speculative and its operand is ready.
- Generalises the single-entry acc station to DEPTH entries, adding same-cycle CDB capture at issue and partial (suffix) flush on branch failure.

Parameters:
- DEPTH, 4, number of queue entries (power of two, >=2).
- B_WIDTH, $clog2(N_B_ENTRY)+1, width of branch-depth counters.
- DATA_W, 32, operand data width (matches cdb_t.data).

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- fpr_read  input  cdb_t[2]  register-read result; only element 0 is used as the operand.
- fpr_cdb  input  cdb_t  common data bus broadcast.
- b_count_next  input  B_WIDTH  branch depth assigned to the instruction being issued.
- b_commit  input  1  one outstanding branch resolved correctly this cycle.
- failure  input  1  branch misprediction; flush speculative state.
- issue_req  req_if  -  valid driven by issue; ready driven by this block.
- acc_req  req_if  -  valid driven by this block; ready driven by the accumulator.
- acc_data  output  DATA_W  head operand data.
- occupancy  output  $clog2(DEPTH)+1  number of live entries.

Behaviour:
- State:
  - circular buffer of DEPTH entries {opd.valid, opd.tag, opd.data, b_count};
  - head pointer and tail pointer, each $clog2(DEPTH) bits, wrapping modulo DEPTH;
  - count register, 0..DEPTH.
- Reset (synchronous): head=tail=count=0.
  - Next cycle: occupancy=0, acc_req.valid=0, issue_req.ready=1.
  - Entry contents don't-care.
  - Reset dominates failure and every other input.
- acc_req.valid = count>0 && head.b_count==0 && head.opd.valid (combinational from registered state).
- acc_data = head.opd.data; don't-care when acc_req.valid=0.
- dispatch = acc_req.valid && acc_req.ready.
  - Head advances and count decrements at the next edge.
  - Zero-cycle latency from the entry becoming eligible to acc_req.valid.
- issue_req.ready = !failure && (count<DEPTH || dispatch).
  - A full queue accepts an issue only in a dispatch cycle.
- enqueue = issue_req.valid && issue_req.ready. The entry written at tail takes:
  - opd.tag from fpr_read[0].tag;
  - opd.valid = fpr_read[0].valid || (fpr_cdb.valid && fpr_cdb.tag==fpr_read[0].tag);
  - opd.data = fpr_read[0].valid ? fpr_read[0].data : fpr_cdb.data (same-cycle bypass);
  - b_count = b_count_next, with no b_commit adjustment.
- Resident entries, every cycle:
  - CDB snoop: if !opd.valid and fpr_cdb.valid and tags match, set opd.valid=1 and latch data.
  - b_count = (b_count==0) ? 0 : b_count - b_commit; saturates at 0 and never underflows.
- Invariant: b_count is non-decreasing from head to tail.
- Failure, checked before branch decrement, on the current registered b_count:
  - Let k = number of entries from head with b_count==0.
  - count becomes k minus (dispatch ? 1 : 0); tail becomes head+k.
  - Confirmed entries keep updating (CDB snoop) and may dispatch in the same cycle.
  - Enqueue is blocked because ready=0 during failure.
  - If k=0, the queue is empty next cycle.
- Simultaneous dispatch + enqueue: count unchanged; both pointers advance.
- Wrap: pointer DEPTH-1 increments to 0; occupancy is never derived from pointer difference alone.
- No combinational path from acc_req.ready to acc_req.valid.

Test Plan:
- Reset held 2 cycles with issue_req.valid=1 -> occupancy=0, acc_req.valid=0, issue_req.ready=1; nothing enqueued.
- acc_req.ready=0; issue 4 entries (valid operands 0x1,0x2,0x3,0x4, b_count 0) -> occupancy=4, issue_req.ready=0. Then set acc_req.ready=1 and keep issuing 0x5 -> acc_data sequence 0x1,0x2,0x3,0x4,0x5 in order, one per cycle, occupancy stays 4 during overlap (pointer wrap exercised).
- Issue tag 7 with operand not ready; two cycles later fpr_cdb={valid,7,0x3f800000} -> acc_req.valid=1 the following cycle with acc_data=0x3f800000. Separately, issue tag 9 while fpr_cdb carries tag 9 in the same cycle -> entry valid at once; acc_req.valid=1 next cycle.
- Entries with b_count 1,1,2 and ready operands, acc_req.ready=1 -> acc_req.valid=0. After b_commit pulse, first two dispatch on consecutive cycles. After a second b_commit, the third dispatches.
- Entries b_count 0,0,1,2; failure asserted with acc_req.ready=1 -> head dispatches and occupancy=1 next cycle, holding the second entry. Issue attempted during failure cycle -> issue_req.ready=0, nothing written.
- Failure with all entries b_count>=1 and b_commit=1 same cycle -> occupancy=0 next cycle, acc_req.valid=0.
